roi_shr_harness: RTL

//  Parametrised serial-to-parallel harness that drives a minitest ROI from three top-level

---
 rtl/roi_harness_pkg.sv | 25 ++
 rtl/roi_shr_harness_if.sv | 29 ++
 rtl/roi_harness_cap_timer.sv | 58 +++++
 rtl/roi_shr_harness.sv | 101 ++++++++++
 4 files changed

// File: rtl/roi_harness_pkg.sv
// Shared constants and helpers for the ROI serial/parallel harness.
package roi_harness_pkg;

  // Capture latency counter width and the largest latency it can express.
  localparam int CAP_LAT_W   = 4;
  localparam int CAP_LAT_MAX = (1 << CAP_LAT_W) - 1;

  // Source selected for the parallel ROI input register on a strobe.
  typedef enum logic [1:0] {
    DIN_SRC_HOLD = 2'd0,   // no strobe: keep the current ROI input
    DIN_SRC_PRE  = 2'd1,   // external strobe: shift register before this cycle's shift
    DIN_SRC_POST = 2'd2    // auto strobe: shift register including this cycle's bit
  } din_src_e;

  // Ceiling log2, minimum 1, used to size the bit counter.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/roi_shr_harness_if.sv
// Pin-side and ROI-side signals of the harness, grouped for one port.
// The serial output is called do_o because "do" is a reserved word.
interface roi_shr_harness_if #(
  parameter int DIN_N  = 256,
  parameter int DOUT_N = 256,
  parameter int FCNT_W = 16
);
  logic              ce;
  logic              di;
  logic              stb;
  logic [DIN_N-1:0]  din;
  logic [DOUT_N-1:0] dout;
  logic              do_o;
  logic              busy;
  logic              overrun;
  logic [FCNT_W-1:0] frame_cnt;

  // Driver side: package pins plus the ROI result bus.
  modport master (
    output ce, di, stb, dout,
    input  din, do_o, busy, overrun, frame_cnt
  );

  // Harness side.
  modport slave (
    input  ce, di, stb, dout,
    output din, do_o, busy, overrun, frame_cnt
  );
endinterface

// File: rtl/roi_harness_cap_timer.sv
// Capture scheduler: turns effective strobes into a capture pulse after
// CAP_LAT cycles and tracks pending / overrun status.
module roi_harness_cap_timer
  import roi_harness_pkg::*;
#(
  parameter int CAP_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb_eff,
  output logic cap_fire,
  output logic busy,
  output logic overrun
);

  localparam logic [CAP_LAT_W-1:0] LOAD_VAL = CAP_LAT_W'(CAP_LAT);
  localparam bit                   TIMED    = (CAP_LAT != 0);

  logic [CAP_LAT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 last_cycle;

  // Countdown, completion and re-arm; a strobe in the final cycle lets the
  // old capture finish before arming the new one, so it is not an overrun.
  always_comb begin
    last_cycle = (cap_cnt_q == CAP_LAT_W'(1));
    cap_cnt_d  = cap_cnt_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
    if (cap_cnt_q != '0) cap_cnt_d = cap_cnt_q - CAP_LAT_W'(1);
    if (last_cycle) busy_d = 1'b0;
    if (TIMED && stb_eff) begin
      cap_cnt_d = LOAD_VAL;
      busy_d    = 1'b1;
      if (busy_q && !last_cycle) overrun_d = 1'b1;
    end
    // Zero latency captures in the strobe cycle itself.
    cap_fire = TIMED ? last_cycle : stb_eff;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_cnt_q <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cap_cnt_q <= cap_cnt_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/roi_shr_harness.sv
// Serial-to-parallel harness for a minitest ROI: shifts di into a DIN_N-bit
// register, hands it to the ROI on a strobe, captures the ROI result after
// CAP_LAT cycles and shifts it back out on do_o.
module roi_shr_harness #(
  parameter int DIN_N    = 256,
  parameter int DOUT_N   = 256,
  parameter int CAP_LAT  = 0,
  parameter int AUTO_STB = 0,
  parameter int FCNT_W   = 16
) (
  input logic               clk,
  input logic               rst_n,
  roi_shr_harness_if.slave  bus
);
  import roi_harness_pkg::*;

  localparam int               BIT_W    = clog2(DIN_N);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DIN_N - 1);

  logic [DIN_N-1:0]  din_shr_q, din_shr_d;
  logic [DIN_N-1:0]  din_q, din_d;
  logic [DOUT_N-1:0] dout_shr_q, dout_shr_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DIN_N-1:0]  din_post;
  logic              auto_stb;
  logic              stb_eff;
  logic              cap_fire;
  logic              busy;
  logic              overrun;
  din_src_e          din_src;

  roi_harness_cap_timer #(
    .CAP_LAT (CAP_LAT)
  ) u_cap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .stb_eff  (stb_eff),
    .cap_fire (cap_fire),
    .busy     (busy),
    .overrun  (overrun)
  );

  // Shift chain, strobe generation, ROI input transfer, capture and counting.
  always_comb begin
    din_post = {din_shr_q[DIN_N-2:0], bus.di};
    auto_stb = (AUTO_STB != 0) && bus.ce && (bit_cnt_q == BIT_LAST);
    stb_eff  = bus.stb | auto_stb;

    // A frame completed by the auto strobe includes the bit arriving now.
    if (auto_stb)     din_src = DIN_SRC_POST;
    else if (bus.stb) din_src = DIN_SRC_PRE;
    else              din_src = DIN_SRC_HOLD;

    din_shr_d = bus.ce ? din_post : din_shr_q;

    case (din_src)
      DIN_SRC_PRE:  din_d = din_shr_q;
      DIN_SRC_POST: din_d = din_post;
      default:      din_d = din_q;
    endcase

    bit_cnt_d = bit_cnt_q;
    if (bus.stb) begin
      bit_cnt_d = '0;
    end else if (bus.ce) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    end

    // The output register continues the input chain; a capture wins.
    if (cap_fire)    dout_shr_d = bus.dout;
    else if (bus.ce) dout_shr_d = {dout_shr_q[DOUT_N-2:0], din_shr_q[DIN_N-1]};
    else             dout_shr_d = dout_shr_q;

    frame_cnt_d = cap_fire ? frame_cnt_q + FCNT_W'(1) : frame_cnt_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_shr_q   <= '0;
      din_q       <= '0;
      dout_shr_q  <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      din_shr_q   <= din_shr_d;
      din_q       <= din_d;
      dout_shr_q  <= dout_shr_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.din       = din_q;
  assign bus.do_o      = dout_shr_q[DOUT_N-1];
  assign bus.busy      = busy;
  assign bus.overrun   = overrun;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
